// File: rtl/cam_pkg.sv
// cam_pkg: shared constants and types for the CAM sequencing front-end.
//   NB_MEM / SIZE_ADDR  : CAM depth and index width
//   SCRUB_KEY_DEFAULT   : reserved filler key written on scrub
//   state_t             : cam_ctrl FSM states
//   RESP_*              : resp_code encodings; OP_* : resp_op encodings
package cam_pkg;

  localparam int unsigned NB_MEM     = 16;
  localparam int unsigned SIZE_ADDR  = 4;
  localparam int unsigned KEY_W      = 8;
  localparam int unsigned CNT_W      = SIZE_ADDR + 1;
  localparam int unsigned CAM_ADDR_W = SIZE_ADDR + 1;
  localparam int unsigned CODE_W     = 2;

  localparam logic [KEY_W-1:0] SCRUB_KEY_DEFAULT = 8'hFF;

  localparam logic [CODE_W-1:0] RESP_OK   = 2'b00;
  localparam logic [CODE_W-1:0] RESP_MISS = 2'b01;
  localparam logic [CODE_W-1:0] RESP_FULL = 2'b10;
  localparam logic [CODE_W-1:0] RESP_DUP  = 2'b11;

  localparam logic OP_LOOKUP = 1'b0;
  localparam logic OP_INSERT = 1'b1;

  typedef enum logic [2:0] {
    ST_SCRUB,
    ST_IDLE,
    ST_LOOK,
    ST_EVAL,
    ST_WRITE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter between the insert and lookup ports.
//   en        : arbitration allowed this cycle
//   ins_valid : insert requester valid
//   lk_valid  : lookup requester valid
//   gnt       : one-hot {insert, lookup}; exactly one bit high whenever en
//   fire      : granted port is also valid (handshake)
module rr_arb2
  import cam_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ins_valid,
  input  logic       lk_valid,
  output logic [1:0] gnt,
  output logic       fire
);

  logic last;
  logic pick_ins;

  // Prefer the port that was not granted last; an idle arbiter still offers
  // ready to that port so exactly one ready is up while enabled.
  always_comb begin
    pick_ins = 1'b0;
    gnt      = 2'b00;
    if (lk_valid) begin
      pick_ins = ins_valid && (last == OP_LOOKUP);
    end else begin
      pick_ins = ins_valid || (last == OP_LOOKUP);
    end
    if (en) begin
      gnt = pick_ins ? 2'b10 : 2'b01;
    end
  end

  assign fire = (gnt[1] && ins_valid) || (gnt[0] && lk_valid);

  // Last granted port; starts at lookup so insert wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= OP_LOOKUP;
    end else if (fire) begin
      last <= gnt[1] ? OP_INSERT : OP_LOOKUP;
    end
  end

endmodule

// File: rtl/cam_ctrl.sv
// cam_ctrl: arbitrates insert/lookup requesters onto a 16-entry CAM, keeps
// keys unique and densely packed, and scrubs the CAM on reset or clr.
//   ins_* / lk_*   : valid/ready request ports with 8-bit keys
//   clr            : scrub request pulse (held pending until serviced)
//   resp_*         : one-cycle registered response (op, code, index)
//   count / busy   : valid-entry count and non-IDLE indication
//   cam_*          : control/data pins of the attached cam instance
module cam_ctrl
  import cam_pkg::*;
#(
  parameter logic [KEY_W-1:0] SCRUB_KEY = SCRUB_KEY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  input  logic [KEY_W-1:0]      ins_key,
  input  logic                  lk_valid,
  output logic                  lk_ready,
  input  logic [KEY_W-1:0]      lk_key,
  input  logic                  clr,
  output logic                  resp_valid,
  output logic                  resp_op,
  output logic [CODE_W-1:0]     resp_code,
  output logic [SIZE_ADDR-1:0]  resp_idx,
  output logic [CNT_W-1:0]      count,
  output logic                  busy,
  output logic                  cam_enable,
  output logic                  cam_write,
  output logic [CAM_ADDR_W-1:0] cam_addr,
  output logic [KEY_W-1:0]      cam_data,
  input  logic [CAM_ADDR_W-1:0] cam_out,
  input  logic                  cam_found
);

  state_t                state_q, state_d;
  logic [SIZE_ADDR-1:0]  ptr_q;
  logic [SIZE_ADDR-1:0]  idx_q;
  logic [CNT_W-1:0]      count_q;
  logic [KEY_W-1:0]      key_q;
  logic                  op_q;
  logic                  clr_pend_q;
  logic                  resp_valid_q;
  logic                  resp_op_q;
  logic [CODE_W-1:0]     resp_code_q;
  logic [SIZE_ADDR-1:0]  resp_idx_q;

  logic                  arb_en;
  logic                  fire;
  logic [1:0]            gnt;
  logic                  resp_load;
  logic                  count_inc;
  logic                  clr_accept;
  logic [CODE_W-1:0]     resp_code_d;
  logic [SIZE_ADDR-1:0]  resp_idx_d;

  // The CAM never reports an index above 15; the top bit carries nothing.
  logic                  unused_cam_msb;
  assign unused_cam_msb = cam_out[SIZE_ADDR];

  assign arb_en = (state_q == ST_IDLE) && !clr_pend_q;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (arb_en),
    .ins_valid (ins_valid),
    .lk_valid  (lk_valid),
    .gnt       (gnt),
    .fire      (fire)
  );

  assign ins_ready  = gnt[1];
  assign lk_ready   = gnt[0];
  assign resp_valid = resp_valid_q;
  assign resp_op    = resp_op_q;
  assign resp_code  = resp_code_q;
  assign resp_idx   = resp_idx_q;
  assign count      = count_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SCRUB;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and decoded CAM controls.
  always_comb begin
    state_d     = state_q;
    busy        = 1'b1;
    cam_enable  = 1'b0;
    cam_write   = 1'b0;
    cam_addr    = '0;
    cam_data    = key_q;
    resp_load   = 1'b0;
    resp_code_d = RESP_OK;
    resp_idx_d  = '0;
    count_inc   = 1'b0;
    clr_accept  = 1'b0;
    case (state_q)
      ST_SCRUB: begin
        cam_write = 1'b1;
        cam_addr  = {1'b0, ptr_q};
        cam_data  = SCRUB_KEY;
        if (ptr_q == SIZE_ADDR'(NB_MEM - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (clr_pend_q) begin
          clr_accept = 1'b1;
          state_d    = ST_SCRUB;
        end else if (fire) begin
          state_d = ST_LOOK;
        end
      end
      ST_LOOK: begin
        // The reserved key never reaches the CAM: it would match every scrubbed slot.
        if (key_q == SCRUB_KEY) begin
          resp_load   = 1'b1;
          resp_code_d = (op_q == OP_INSERT) ? RESP_DUP : RESP_MISS;
          state_d     = ST_RESP;
        end else begin
          cam_enable = 1'b1;
          state_d    = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (op_q == OP_LOOKUP) begin
          resp_load   = 1'b1;
          resp_code_d = cam_found ? RESP_OK : RESP_MISS;
          resp_idx_d  = cam_found ? idx_q : '0;
          state_d     = ST_RESP;
        end else if (cam_found) begin
          resp_load   = 1'b1;
          resp_code_d = RESP_DUP;
          resp_idx_d  = idx_q;
          state_d     = ST_RESP;
        end else if (count_q == CNT_W'(NB_MEM)) begin
          resp_load   = 1'b1;
          resp_code_d = RESP_FULL;
          state_d     = ST_RESP;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // No deletes, so the next free slot is always count.
        cam_write   = 1'b1;
        cam_addr    = {1'b0, count_q[SIZE_ADDR-1:0]};
        count_inc   = 1'b1;
        resp_load   = 1'b1;
        resp_code_d = RESP_OK;
        resp_idx_d  = count_q[SIZE_ADDR-1:0];
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_SCRUB;
      end
    endcase
  end

  // Datapath: scrub pointer, entry count, latched request, pending clear, response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      count_q      <= '0;
      key_q        <= '0;
      op_q         <= OP_LOOKUP;
      idx_q        <= '0;
      clr_pend_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_op_q    <= OP_LOOKUP;
      resp_code_q  <= RESP_OK;
      resp_idx_q   <= '0;
    end else begin
      ptr_q <= (state_q == ST_SCRUB) ? ptr_q + SIZE_ADDR'(1) : '0;

      if (clr_accept || state_q == ST_SCRUB) begin
        count_q <= '0;
      end else if (count_inc) begin
        count_q <= count_q + CNT_W'(1);
      end

      if (fire) begin
        key_q <= gnt[1] ? ins_key : lk_key;
        op_q  <= gnt[1] ? OP_INSERT : OP_LOOKUP;
      end

      // cam_out is only meaningful while cam_data still holds the key.
      if (state_q == ST_LOOK) idx_q <= cam_out[SIZE_ADDR-1:0];

      clr_pend_q <= clr || (clr_pend_q && !clr_accept);

      resp_valid_q <= resp_load;
      if (resp_load) begin
        resp_op_q   <= op_q;
        resp_code_q <= resp_code_d;
        resp_idx_q  <= resp_idx_d;
      end
    end
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: self-checking bench for cam_ctrl with a behavioural CAM and a
// queue-based reference model of the key store.
module tb_cam_ctrl;
  import cam_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ins_valid, ins_ready, lk_valid, lk_ready, clr;
  logic [7:0] ins_key, lk_key;
  logic       resp_valid, resp_op;
  logic [1:0] resp_code;
  logic [3:0] resp_idx;
  logic [4:0] count;
  logic       busy, cam_enable, cam_write;
  logic [4:0] cam_addr, cam_out;
  logic [7:0] cam_data;
  logic       cam_found;

  cam_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_key(ins_key),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key),
    .clr(clr),
    .resp_valid(resp_valid), .resp_op(resp_op), .resp_code(resp_code), .resp_idx(resp_idx),
    .count(count), .busy(busy),
    .cam_enable(cam_enable), .cam_write(cam_write), .cam_addr(cam_addr),
    .cam_data(cam_data), .cam_out(cam_out), .cam_found(cam_found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CAM: OR-combined index, registered found flag.
  logic [7:0] mem [16];
  logic       hit;
  initial for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
  always_comb begin
    cam_out = 5'd0;
    hit     = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (mem[i] == cam_data) begin
        cam_out = cam_out | 5'(i);
        hit     = 1'b1;
      end
    end
  end
  always @(posedge clk) begin
    if (cam_write) mem[cam_addr[3:0]] <= cam_data;
    cam_found <= cam_enable && hit;
  end

  int n_pass = 0;
  int n_chk  = 0;
  int n_en   = 0;
  int n_wr   = 0;
  int n_viol = 0;

  always @(posedge clk) if (rst_n) begin
    if (cam_enable) n_en++;
    if (cam_write)  n_wr++;
  end

  always @(negedge clk) if (rst_n) begin
    if ((cam_enable && cam_write) || cam_addr[4] || ((ins_ready || lk_ready) && busy) ||
        (ins_ready && lk_ready))
      n_viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: stored keys in insertion order; the slot is the queue position.
  logic [7:0] mdl_q[$];

  task automatic model_op(input bit is_ins, input logic [7:0] key,
                          output logic [1:0] code, output logic [3:0] idx, output int lat);
    int pos;
    pos = -1;
    foreach (mdl_q[i]) if (mdl_q[i] == key) pos = i;
    idx = 4'd0;
    if (key == 8'hFF) begin
      code = is_ins ? 2'b11 : 2'b01;
      lat  = 2;
    end else if (!is_ins) begin
      lat  = 3;
      code = (pos >= 0) ? 2'b00 : 2'b01;
      if (pos >= 0) idx = 4'(pos);
    end else if (pos >= 0) begin
      code = 2'b11; idx = 4'(pos); lat = 3;
    end else if (mdl_q.size() == 16) begin
      code = 2'b10; lat = 3;
    end else begin
      code = 2'b00; idx = 4'(mdl_q.size()); lat = 4;
      mdl_q.push_back(key);
    end
  endtask

  task automatic issue(input bit is_ins, input logic [7:0] key, output int lat, output logic rop,
                       output logic [1:0] rcode, output logic [3:0] ridx,
                       output int d_en, output int d_wr);
    int waits, en0, wr0;
    waits = 0; lat = -1; rop = 1'b0; rcode = 2'b00; ridx = 4'd0; d_en = 0; d_wr = 0;
    if (is_ins) begin ins_valid = 1'b1; ins_key = key; end
    else begin lk_valid = 1'b1; lk_key = key; end
    #1;
    while (!(is_ins ? ins_ready : lk_ready) && waits < 64) begin
      @(negedge clk); #1; waits++;
    end
    if (waits >= 64) begin
      check("grant_timeout", 32'd1, 32'd0);
      ins_valid = 1'b0; lk_valid = 1'b0;
      return;
    end
    en0 = n_en; wr0 = n_wr;
    @(negedge clk);
    ins_valid = 1'b0; lk_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (resp_valid) begin
        lat = k; rop = resp_op; rcode = resp_code; ridx = resp_idx;
        break;
      end
      @(negedge clk);
    end
    d_en = n_en - en0;
    d_wr = n_wr - wr0;
  endtask

  task automatic run_exp(input string name, input bit is_ins, input logic [7:0] key,
                         input logic [1:0] ecode, input logic [3:0] eidx,
                         input int elat, input int ecnt);
    int lat, d_en, d_wr;
    logic rop;
    logic [1:0] rc;
    logic [3:0] ri;
    issue(is_ins, key, lat, rop, rc, ri, d_en, d_wr);
    check({name, "/lat"},   32'(lat), 32'(elat));
    check({name, "/op"},    32'(rop), 32'(is_ins));
    check({name, "/code"},  32'(rc),  32'(ecode));
    check({name, "/idx"},   32'(ri),  32'(eidx));
    check({name, "/count"}, 32'(count), 32'(ecnt));
    check({name, "/cam_en"}, 32'(d_en), (key == 8'hFF) ? 32'd0 : 32'd1);
    check({name, "/cam_wr"}, 32'(d_wr),
          (is_ins && ecode == 2'b00 && key != 8'hFF) ? 32'd1 : 32'd0);
  endtask

  task automatic do_reset();
    ins_valid = 1'b0; lk_valid = 1'b0; clr = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (16) @(negedge clk);
    mdl_q.delete();
  endtask

  typedef struct {
    bit         is_ins;
    logic [7:0] key;
    logic [1:0] code;
    logic [3:0] idx;
    int         lat;
    int         cnt;
  } vec_t;

  vec_t       tbl[6];
  logic       rr_op[4];
  logic [1:0] rr_code[4];
  logic       exp_op[4];
  logic [1:0] exp_code[4];

  initial begin
    int rr_n, seen;
    logic [1:0] ec;
    logic [3:0] ei;
    int el;

    tbl[0] = '{1'b1, 8'h3C, 2'b00, 4'd0, 4, 1};
    tbl[1] = '{1'b0, 8'h3C, 2'b00, 4'd0, 3, 1};
    tbl[2] = '{1'b0, 8'h55, 2'b01, 4'd0, 3, 1};
    tbl[3] = '{1'b1, 8'h3C, 2'b11, 4'd0, 3, 1};
    tbl[4] = '{1'b1, 8'hFF, 2'b11, 4'd0, 2, 1};
    tbl[5] = '{1'b0, 8'hFF, 2'b01, 4'd0, 2, 1};

    rst_n = 1'b0; ins_valid = 1'b0; lk_valid = 1'b0; clr = 1'b0;
    ins_key = 8'h00; lk_key = 8'h00;

    // Reset values and scrub sweep.
    @(negedge clk);
    check("rst/busy", 32'(busy), 32'd1);
    check("rst/cam_wr", 32'(cam_write), 32'd1);
    check("rst/cam_addr", 32'(cam_addr), 32'd0);
    check("rst/cam_data", 32'(cam_data), 32'hFF);
    check("rst/resp_valid", 32'(resp_valid), 32'd0);
    check("rst/count", 32'(count), 32'd0);
    check("rst/ready", 32'({ins_ready, lk_ready}), 32'd0);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("scrub[%0d]", i), 32'({cam_write, busy, cam_addr, cam_data}),
            32'({1'b1, 1'b1, 5'(i), 8'hFF}));
    end
    @(negedge clk);
    check("post_scrub/busy", 32'(busy), 32'd0);
    check("post_scrub/count", 32'(count), 32'd0);
    check("post_scrub/ready", 32'({ins_ready, lk_ready}), 32'b10);
    check("post_scrub/cam_wr", 32'(cam_write), 32'd0);

    // Directed vectors: insert, hit, miss, duplicate, reserved key.
    for (int i = 0; i < 6; i++)
      run_exp($sformatf("tbl[%0d]", i), tbl[i].is_ins, tbl[i].key, tbl[i].code,
              tbl[i].idx, tbl[i].lat, tbl[i].cnt);

    // Fill to full, overflow, then look every key back up.
    do_reset();
    for (int k = 0; k < 16; k++)
      run_exp($sformatf("fill[%0d]", k), 1'b1, 8'(16 + k), 2'b00, 4'(k), 4, k + 1);
    run_exp("full", 1'b1, 8'hA0, 2'b10, 4'd0, 3, 16);
    for (int k = 0; k < 16; k++)
      run_exp($sformatf("refind[%0d]", k), 1'b0, 8'(16 + k), 2'b00, 4'(k), 3, 16);

    // Round-robin with both ports held valid.
    do_reset();
    exp_op[0] = 1'b1; exp_op[1] = 1'b0; exp_op[2] = 1'b1; exp_op[3] = 1'b0;
    exp_code[0] = 2'b00; exp_code[1] = 2'b00; exp_code[2] = 2'b11; exp_code[3] = 2'b00;
    ins_valid = 1'b1; ins_key = 8'h40; lk_valid = 1'b1; lk_key = 8'h40;
    rr_n = 0;
    for (int c = 0; c < 60 && rr_n < 4; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        rr_op[rr_n] = resp_op; rr_code[rr_n] = resp_code; rr_n++;
      end
    end
    ins_valid = 1'b0; lk_valid = 1'b0;
    check("rr/responses", 32'(rr_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rr_n) begin
        check($sformatf("rr[%0d]/op", i), 32'(rr_op[i]), 32'(exp_op[i]));
        check($sformatf("rr[%0d]/code", i), 32'(rr_code[i]), 32'(exp_code[i]));
      end
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 120; n++) begin
      int r;
      bit is_ins;
      logic [7:0] key;
      r = int'($urandom_range(0, 20));
      key = (r == 20) ? 8'hFF : 8'(r * 11 + 3);
      is_ins = ($urandom_range(0, 99) < 55);
      model_op(is_ins, key, ec, ei, el);
      run_exp($sformatf("rnd[%0d]", n), is_ins, key, ec, ei, el, mdl_q.size());
    end

    // Clear pulsed during EVAL of a lookup.
    do_reset();
    run_exp("clr/ins", 1'b1, 8'h3C, 2'b00, 4'd0, 4, 1);
    lk_valid = 1'b1; lk_key = 8'h3C;
    #1;
    for (int w = 0; w < 64 && !lk_ready; w++) begin
      @(negedge clk); #1;
    end
    check("clr/granted", 32'(lk_ready), 32'd1);
    @(negedge clk); lk_valid = 1'b0;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("clr/resp", 32'({resp_valid, resp_op, resp_code, resp_idx}),
          32'({1'b1, 1'b0, 2'b00, 4'd0}));
    @(negedge clk);
    check("clr/blocked", 32'({busy, ins_ready, lk_ready}), 32'd0);
    @(negedge clk);
    check("clr/scrub", 32'({busy, cam_write, cam_addr}), 32'({1'b1, 1'b1, 5'd0}));
    repeat (16) @(negedge clk);
    mdl_q.delete();
    run_exp("clr/lookup", 1'b0, 8'h3C, 2'b01, 4'd0, 3, 0);

    // Async reset during WRITE drops the response and restarts scrub at 0.
    ins_valid = 1'b1; ins_key = 8'h77;
    #1;
    for (int w = 0; w < 64 && !ins_ready; w++) begin
      @(negedge clk); #1;
    end
    @(negedge clk); ins_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("arst/write", 32'({cam_write, cam_addr, cam_data}), 32'({1'b1, 5'd0, 8'h77}));
    #2 rst_n = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    rst_n = 1'b1;
    #1;
    check("arst/restart", 32'({busy, cam_write, cam_addr}), 32'({1'b1, 1'b1, 5'd0}));
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("arst/no_resp", 32'(seen), 32'd0);
    @(negedge clk);
    check("arst/count", 32'(count), 32'd0);
    run_exp("arst/lookup", 1'b0, 8'h77, 2'b01, 4'd0, 3, 0);

    check("protocol", 32'(n_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
